// File: rtl/ucsbece154b_pht_ctrl_if.sv
// Core/PHT-side bundle for the GShare PHT controller.
// The slave modport is the controller; the master modport is the fetch/execute pipe plus the PHT macro.
interface ucsbece154b_pht_ctrl_if #(
    parameter int GHR_BITS = 5
);
    logic                lkp_valid_i;
    logic [31:0]         lkp_pc_i;
    logic                lkp_ready_o;
    logic                lkp_rsp_valid_o;
    logic                lkp_taken_o;
    logic [GHR_BITS-1:0] lkp_idx_o;
    logic [GHR_BITS-1:0] lkp_ghr_o;

    logic                upd_valid_i;
    logic                upd_ready_o;
    logic [GHR_BITS-1:0] upd_idx_i;
    logic                upd_taken_i;
    logic                upd_mispred_i;
    logic [GHR_BITS-1:0] upd_ghr_i;

    logic                pht_en_o;
    logic                pht_we_o;
    logic [GHR_BITS-1:0] pht_addr_o;
    logic [1:0]          pht_wdata_o;
    logic [1:0]          pht_rdata_i;

    modport slave (
        input  lkp_valid_i, lkp_pc_i,
        output lkp_ready_o, lkp_rsp_valid_o, lkp_taken_o, lkp_idx_o, lkp_ghr_o,
        input  upd_valid_i, upd_idx_i, upd_taken_i, upd_mispred_i, upd_ghr_i,
        output upd_ready_o,
        output pht_en_o, pht_we_o, pht_addr_o, pht_wdata_o,
        input  pht_rdata_i
    );

    modport master (
        output lkp_valid_i, lkp_pc_i,
        input  lkp_ready_o, lkp_rsp_valid_o, lkp_taken_o, lkp_idx_o, lkp_ghr_o,
        output upd_valid_i, upd_idx_i, upd_taken_i, upd_mispred_i, upd_ghr_i,
        input  upd_ready_o,
        input  pht_en_o, pht_we_o, pht_addr_o, pht_wdata_o,
        output pht_rdata_i
    );
endinterface

// File: rtl/ucsbece154b_pht_ctrl.sv
// GShare PHT port arbiter + GHR owner: lookups answer 1 cycle after grant, updates are queued and done as 2-cycle RMWs.
// Lookups stall only while the update FIFO is full or an RMW write is in flight; PHT_INIT_SWEEP_EN adds a post-reset init sweep.
module ucsbece154b_pht_ctrl #(
    parameter int         GHR_BITS  = 5,
    parameter int         UPD_DEPTH = 2,
    parameter logic [1:0] CNT_INIT  = 2'b01
) (
    input  logic                  clk,
    input  logic                  reset,
    ucsbece154b_pht_ctrl_if.slave bus
);
    localparam int PW = $clog2(UPD_DEPTH);
    localparam logic [PW:0] DEPTH_L = UPD_DEPTH[PW:0];

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_UPD_WR = 2'd1;
`ifdef PHT_INIT_SWEEP_EN
    localparam logic [1:0] S_INIT   = 2'd2;
    logic [GHR_BITS-1:0] r_init_addr;
`else
    logic w_unused_init;
    assign w_unused_init = ^CNT_INIT;
`endif

    logic [1:0]          r_state, w_state_nxt;
    logic [GHR_BITS-1:0] r_ghr, w_ghr_eff, w_idx;
    logic [GHR_BITS-1:0] r_lkp_idx, r_lkp_ghr;
    logic                r_rsp_vld;

    logic [GHR_BITS-1:0] r_fifo_idx [UPD_DEPTH];
    logic                r_fifo_tkn [UPD_DEPTH];
    logic [PW:0]         r_wptr, r_rptr, w_count;
    logic [GHR_BITS-1:0] w_head_idx;
    logic                w_head_tkn;
    logic                w_full, w_empty, w_push, w_pop, w_grant, w_init, w_upd_rdy;

    logic                w_en, w_we;
    logic [GHR_BITS-1:0] w_addr;
    logic [1:0]          w_wdata, w_sat, w_rd;
    logic                w_unused_pc;

    assign w_unused_pc = ^{bus.lkp_pc_i[31:GHR_BITS+2], bus.lkp_pc_i[1:0]};

    assign w_count    = r_wptr - r_rptr;
    assign w_full     = (w_count == DEPTH_L);
    assign w_empty    = (r_wptr == r_rptr);
    assign w_head_idx = r_fifo_idx[r_rptr[PW-1:0]];
    assign w_head_tkn = r_fifo_tkn[r_rptr[PW-1:0]];
`ifdef PHT_INIT_SWEEP_EN
    assign w_init     = (r_state == S_INIT);
`else
    assign w_init     = 1'b0;
`endif
    assign w_upd_rdy  = !w_full && !w_init;
    assign w_push     = bus.upd_valid_i && w_upd_rdy;

    // The response arriving this cycle shifts the GHR at the clock edge; a back-to-back lookup must already see it.
    assign w_ghr_eff = r_rsp_vld ? {r_ghr[GHR_BITS-2:0], bus.pht_rdata_i[1]} : r_ghr;
    assign w_idx     = bus.lkp_pc_i[GHR_BITS+1:2] ^ w_ghr_eff;

    assign w_rd  = bus.pht_rdata_i;
    assign w_sat = w_head_tkn ? ((w_rd == 2'b11) ? 2'b11 : w_rd + 2'b01)
                              : ((w_rd == 2'b00) ? 2'b00 : w_rd - 2'b01);

    always_comb begin
        w_state_nxt = r_state;
        w_en        = 1'b0;
        w_we        = 1'b0;
        w_addr      = '0;
        w_wdata     = 2'b00;
        w_grant     = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_full) begin
                    w_en        = 1'b1;
                    w_addr      = w_head_idx;
                    w_state_nxt = S_UPD_WR;
                end else if (bus.lkp_valid_i) begin
                    w_en    = 1'b1;
                    w_grant = 1'b1;
                    w_addr  = w_idx;
                end else if (!w_empty) begin
                    w_en        = 1'b1;
                    w_addr      = w_head_idx;
                    w_state_nxt = S_UPD_WR;
                end
            end
            S_UPD_WR: begin
                w_en        = 1'b1;
                w_we        = 1'b1;
                w_addr      = w_head_idx;
                w_wdata     = w_sat;
                w_pop       = 1'b1;
                w_state_nxt = S_IDLE;
            end
`ifdef PHT_INIT_SWEEP_EN
            S_INIT: begin
                w_en    = 1'b1;
                w_we    = 1'b1;
                w_addr  = r_init_addr;
                w_wdata = CNT_INIT;
                if (&r_init_addr) w_state_nxt = S_IDLE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
`ifdef PHT_INIT_SWEEP_EN
            r_state     <= S_INIT;
            r_init_addr <= '0;
`else
            r_state     <= S_IDLE;
`endif
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_rsp_vld <= 1'b0;
            r_lkp_idx <= '0;
            r_lkp_ghr <= '0;
            r_ghr     <= '0;
        end else begin
            r_state   <= w_state_nxt;
`ifdef PHT_INIT_SWEEP_EN
            if (w_init) r_init_addr <= r_init_addr + 1'b1;
`endif
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_rsp_vld <= w_grant;
            if (w_grant) begin
                r_lkp_idx <= w_idx;
                r_lkp_ghr <= w_ghr_eff;
            end
            // A mispredict restore wins over the speculative shift from a response in the same cycle.
            if (w_push && bus.upd_mispred_i)
                r_ghr <= {bus.upd_ghr_i[GHR_BITS-2:0], bus.upd_taken_i};
            else if (r_rsp_vld)
                r_ghr <= {r_ghr[GHR_BITS-2:0], bus.pht_rdata_i[1]};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_idx[r_wptr[PW-1:0]] <= bus.upd_idx_i;
            r_fifo_tkn[r_wptr[PW-1:0]] <= bus.upd_taken_i;
        end
    end

    assign bus.lkp_ready_o     = w_grant;
    assign bus.lkp_rsp_valid_o = r_rsp_vld;
    assign bus.lkp_taken_o     = r_rsp_vld & bus.pht_rdata_i[1];
    assign bus.lkp_idx_o       = r_lkp_idx;
    assign bus.lkp_ghr_o       = r_lkp_ghr;
    assign bus.upd_ready_o     = w_upd_rdy;
    assign bus.pht_en_o        = w_en;
    assign bus.pht_we_o        = w_we;
    assign bus.pht_addr_o      = w_addr;
    assign bus.pht_wdata_o     = w_wdata;
endmodule
